// File: rtl/pdp_rdma_egress_fmt_if.sv
// Read-return input and core-facing output handshake bundle for pdp_rdma_egress_fmt.
// The slave modport is the formatter's view; the master modport drives it.
interface pdp_rdma_egress_fmt_if;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 14;

  logic [DW-1:0]    rd_data_pd;
  logic             rd_data_valid;
  logic             rd_data_ready;
  logic [DW+IW-1:0] pdp_rdma2dp_pd;
  logic             pdp_rdma2dp_valid;
  logic             pdp_rdma2dp_ready;

  modport slave (
    input  rd_data_pd, rd_data_valid, pdp_rdma2dp_ready,
    output rd_data_ready, pdp_rdma2dp_pd, pdp_rdma2dp_valid
  );

  modport master (
    output rd_data_pd, rd_data_valid, pdp_rdma2dp_ready,
    input  rd_data_ready, pdp_rdma2dp_pd, pdp_rdma2dp_valid
  );
endinterface

// File: rtl/pdp_rdma_egress_fmt.sv
// PDP RDMA egress formatter: tags read-return beats with cube position/end bits.
// Optional stall counter enabled by defining PDP_RDMA_EGRESS_STALL_CNT_EN.
module pdp_rdma_egress_fmt (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 reg2dp_op_en,
  input  logic [12:0]          reg2dp_cube_in_width,
  input  logic [12:0]          reg2dp_cube_in_height,
  input  logic [7:0]           reg2dp_cube_in_surf,
  input  logic [7:0]           reg2dp_split_num,
  pdp_rdma_egress_fmt_if.slave dp,
  output logic                 rdma_layer_done,
  output logic                 rdma_busy,
  output logic [31:0]          dp2reg_rdma_stall
);
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 14;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q;
  logic             op_en_d1_q;
  logic [12:0]      w_sh_q, h_sh_q, w_cnt_q, h_cnt_q, w_cnt_d, h_cnt_d;
  logic [7:0]       s_sh_q, n_sh_q, s_cnt_q, n_cnt_q, s_cnt_d, n_cnt_d;
  logic [DW+IW-1:0] pd_q;
  logic             valid_q, done_q, busy_q;

  logic             op_en_rise_c, load_c;
  logic             w_end_c, h_end_c, s_end_c, n_end_c;
  logic [IW-1:0]    info_c;

  assign op_en_rise_c     = reg2dp_op_en & ~op_en_d1_q;
  assign dp.rd_data_ready = (state_q == RUN) & (~valid_q | dp.pdp_rdma2dp_ready);
  assign load_c           = dp.rd_data_valid & dp.rd_data_ready;

  // End flags chain from innermost (width) outward; cube_end aliases surf_end.
  always_comb begin
    w_end_c    = (w_cnt_q == w_sh_q);
    h_end_c    = w_end_c & (h_cnt_q == h_sh_q);
    s_end_c    = h_end_c & (s_cnt_q == s_sh_q);
    n_end_c    = s_end_c & (n_cnt_q == n_sh_q);
    info_c     = '0;
    info_c[0]  = w_end_c;
    info_c[1]  = h_end_c;
    info_c[2]  = s_end_c;
    info_c[9]  = n_end_c;
    info_c[13] = s_end_c;
    w_cnt_d    = w_cnt_q;
    h_cnt_d    = h_cnt_q;
    s_cnt_d    = s_cnt_q;
    n_cnt_d    = n_cnt_q;
    if (load_c) begin
      w_cnt_d = w_end_c ? 13'd0 : w_cnt_q + 13'd1;
      if (w_end_c) h_cnt_d = h_end_c ? 13'd0 : h_cnt_q + 13'd1;
      if (h_end_c) s_cnt_d = s_end_c ? 8'd0 : s_cnt_q + 8'd1;
      if (s_end_c) n_cnt_d = n_end_c ? 8'd0 : n_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      op_en_d1_q <= 1'b0;
      w_sh_q     <= '0;
      h_sh_q     <= '0;
      s_sh_q     <= '0;
      n_sh_q     <= '0;
      w_cnt_q    <= '0;
      h_cnt_q    <= '0;
      s_cnt_q    <= '0;
      n_cnt_q    <= '0;
      pd_q       <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      op_en_d1_q <= reg2dp_op_en;
      done_q     <= 1'b0;
      w_cnt_q    <= w_cnt_d;
      h_cnt_q    <= h_cnt_d;
      s_cnt_q    <= s_cnt_d;
      n_cnt_q    <= n_cnt_d;
      // Single-entry output register; a load overwrites an accepted beat with no bubble.
      if (load_c) begin
        pd_q    <= {info_c, dp.rd_data_pd};
        valid_q <= 1'b1;
      end else if (dp.pdp_rdma2dp_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (op_en_rise_c) begin
            w_sh_q  <= reg2dp_cube_in_width;
            h_sh_q  <= reg2dp_cube_in_height;
            s_sh_q  <= reg2dp_cube_in_surf;
            n_sh_q  <= reg2dp_split_num;
            w_cnt_q <= '0;
            h_cnt_q <= '0;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (load_c && n_end_c) state_q <= DONE;
        end
        DONE: begin
          if (!valid_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dp.pdp_rdma2dp_pd    = pd_q;
  assign dp.pdp_rdma2dp_valid = valid_q;
  assign rdma_layer_done      = done_q;
  assign rdma_busy            = busy_q;

`ifdef PDP_RDMA_EGRESS_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of core back-pressure cycles for the current layer.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE) begin
      if (op_en_rise_c) stall_q <= '0;
    end else if (valid_q && !dp.pdp_rdma2dp_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign dp2reg_rdma_stall = stall_q;
`else
  assign dp2reg_rdma_stall = 32'd0;
`endif

endmodule

// File: tb/tb_pdp_rdma_egress_fmt.sv
// Scoreboard bench for pdp_rdma_egress_fmt: directed layers, queue-based output checking.
module tb_pdp_rdma_egress_fmt;
  logic        clk;
  logic        rst;
  logic        op_en;
  logic [12:0] cw, ch;
  logic [7:0]  cs, cn;
  logic        done, busy;
  logic [31:0] stall;

  pdp_rdma_egress_fmt_if bus ();

  pdp_rdma_egress_fmt dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .reg2dp_op_en          (op_en),
    .reg2dp_cube_in_width  (cw),
    .reg2dp_cube_in_height (ch),
    .reg2dp_cube_in_surf   (cs),
    .reg2dp_split_num      (cn),
    .dp                    (bus),
    .rdma_layer_done       (done),
    .rdma_busy             (busy),
    .dp2reg_rdma_stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [77:0] exp_q[$];
  logic [63:0] data_q[$];
  int rmode = 0;
  int rphase = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc_cyc = 0;
  int stall_model = 0;
  logic        held = 1'b0;
  logic [77:0] held_pd;

  task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Core ready pattern: 0=always ready, 1=repeat 1,0,0, 2=held low.
  always @(negedge clk) begin
    case (rmode)
      0: bus.pdp_rdma2dp_ready = 1'b1;
      1: begin
        bus.pdp_rdma2dp_ready = (rphase == 0);
        rphase = (rphase + 1) % 3;
      end
      default: bus.pdp_rdma2dp_ready = 1'b0;
    endcase
  end

  // Monitor: pre-edge values seen at posedge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_hold_valid", 78'(bus.pdp_rdma2dp_valid), 78'd1);
        chk("stall_hold_pd", bus.pdp_rdma2dp_pd, held_pd);
      end
      held = bus.pdp_rdma2dp_valid && !bus.pdp_rdma2dp_ready;
      held_pd = bus.pdp_rdma2dp_pd;
      if (held) stall_model++;
      if (bus.pdp_rdma2dp_valid && bus.pdp_rdma2dp_ready) begin
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus.pdp_rdma2dp_pd, 78'd0);
        end else begin
          chk("beat", bus.pdp_rdma2dp_pd, exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", 78'(busy), 78'd0);
      end
    end
  end

  // Nested-loop reference: width innermost, then height, surface, split.
  task automatic push_layer(input int w, input int h, input int s, input int n, input logic [31:0] base);
    int idx = 0;
    for (int k = 0; k <= n; k++)
      for (int z = 0; z <= s; z++)
        for (int y = 0; y <= h; y++)
          for (int x = 0; x <= w; x++) begin
            logic we, he, se, pe;
            logic [63:0] d;
            we = (x == w);
            he = we && (y == h);
            se = he && (z == s);
            pe = se && (k == n);
            d = {base, 32'(idx)};
            data_q.push_back(d);
            exp_q.push_back({se, 3'b000, pe, 6'b000000, se, he, we, d});
            idx++;
          end
  endtask

  task automatic set_size(input int w, input int h, input int s, input int n);
    cw = 13'(w); ch = 13'(h); cs = 8'(s); cn = 8'(n);
  endtask

  task automatic pulse_op_en();
    @(negedge clk) op_en = 1'b1;
    @(negedge clk) op_en = 1'b0;
  endtask

  // Presents beats from data_q; a beat moves when ready is seen high just before the edge.
  task automatic feed(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int tries = 0;
      @(negedge clk);
      bus.rd_data_valid = 1'b1;
      bus.rd_data_pd = data_q.pop_front();
      #4;
      while (!bus.rd_data_ready && tries < 200) begin
        @(negedge clk);
        #4;
        tries++;
      end
      if (tries >= 200) begin
        checks++; errors++;
        $display("FAIL feed_timeout: beat %0d never accepted", i);
      end
    end
    @(negedge clk) bus.rd_data_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    int t = 0;
    while (done_cnt < exp_cnt && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_count", 78'(done_cnt), 78'(exp_cnt));
    @(negedge clk);
    chk("busy_after_done", 78'(busy), 78'd0);
  endtask

  initial begin
    rst = 1'b1; op_en = 1'b0;
    bus.rd_data_valid = 1'b0; bus.rd_data_pd = '0; bus.pdp_rdma2dp_ready = 1'b1;
    set_size(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 78'(bus.pdp_rdma2dp_valid), 78'd0);
    chk("rst_pd", bus.pdp_rdma2dp_pd, 78'd0);
    chk("rst_done", 78'(done), 78'd0);
    chk("rst_busy", 78'(busy), 78'd0);
    chk("rst_rd_ready", 78'(bus.rd_data_ready), 78'd0);
    chk("rst_stall", 78'(stall), 78'd0);

    // T1: two beats, hand-computed info.
    set_size(1, 0, 0, 0);
    pulse_op_en();
    chk("t1_busy", 78'(busy), 78'd1);
    data_q.push_back(64'h1111_0000_0000_0000);
    data_q.push_back(64'h1111_0000_0000_0001);
    exp_q.push_back({14'h0000, 64'h1111_0000_0000_0000});
    exp_q.push_back({14'h2207, 64'h1111_0000_0000_0001});
    feed(2);
    wait_done(1);
    chk("t1_done_lag", 78'(done_cyc - last_acc_cyc), 78'd2);

    // T2: 16 beats, all sizes 1.
    set_size(1, 1, 1, 1);
    pulse_op_en();
    push_layer(1, 1, 1, 1, 32'h2222_0000);
    feed(16);
    wait_done(2);

    // T3: T2 with core back-pressure.
    rmode = 1; rphase = 0; stall_model = 0;
    pulse_op_en();
    push_layer(1, 1, 1, 1, 32'h3333_0000);
    feed(16);
    wait_done(3);
`ifdef PDP_RDMA_EGRESS_STALL_CNT_EN
    chk("t3_stall_cnt", 78'(stall), 78'(stall_model));
    chk("t3_stall_nonzero", 78'(stall_model > 0), 78'd1);
`else
    chk("t3_stall_cnt", 78'(stall), 78'd0);
`endif
    rmode = 0;

    // T4: mid-layer size rewrite and op_en pulse are ignored.
    set_size(1, 0, 0, 0);
    pulse_op_en();
    push_layer(1, 0, 0, 0, 32'h4444_0000);
    feed(1);
    cw = 13'd5;
    pulse_op_en();
    feed(1);
    wait_done(4);
    pulse_op_en();
    push_layer(5, 0, 0, 0, 32'h4545_0000);
    feed(6);
    wait_done(5);

    // T5: reset with a beat stuck in the output register, then rerun T1.
    set_size(1, 0, 0, 0);
    rmode = 2;
    pulse_op_en();
    push_layer(1, 0, 0, 0, 32'h1111_0000);
    feed(1);
    @(negedge clk) rst = 1'b1;
    exp_q.delete();
    data_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; rmode = 0;
    repeat (5) @(negedge clk);
    chk("t5_no_done", 78'(done_cnt), 78'd5);
    chk("t5_idle_busy", 78'(busy), 78'd0);
    pulse_op_en();
    data_q.push_back(64'h1111_0000_0000_0000);
    data_q.push_back(64'h1111_0000_0000_0001);
    exp_q.push_back({14'h0000, 64'h1111_0000_0000_0000});
    exp_q.push_back({14'h2207, 64'h1111_0000_0000_0001});
    feed(2);
    wait_done(6);
    chk("t5_done_lag", 78'(done_cyc - last_acc_cyc), 78'd2);

    // T6: zero-size layer, valid held high afterwards.
    set_size(0, 0, 0, 0);
    pulse_op_en();
    data_q.push_back(64'h6666_0000_0000_0000);
    exp_q.push_back({14'h2207, 64'h6666_0000_0000_0000});
    feed(1);
    bus.rd_data_valid = 1'b1;
    wait_done(7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("t6_rd_ready_low", 78'(bus.rd_data_ready), 78'd0);
    end
    bus.rd_data_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 78'(exp_q.size()), 78'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
